// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: frame width, default bit period
// and the transmitter state encoding.
package uart_pkg;

  localparam int unsigned UartDataBits   = 8;
  localparam int unsigned UartClksPerBit = 868;  // 100 MHz / 115200 baud

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Upstream FIFO read port plus serial-side status of the UART transmitter.
// master = transmitter, slave = FIFO / line observer.
interface fifo_uart_tx_if;
  import uart_pkg::*;

  logic [UartDataBits-1:0] fifo_data;
  logic                    fifo_empty;
  logic                    fifo_read_en;
  logic                    tx;
  logic                    busy;
  logic                    tx_done;

  modport master (
    input  fifo_data,
    input  fifo_empty,
    output fifo_read_en,
    output tx,
    output busy,
    output tx_done
  );

  modport slave (
    output fifo_data,
    output fifo_empty,
    input  fifo_read_en,
    input  tx,
    input  busy,
    input  tx_done
  );

endinterface

// File: rtl/baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last count.
module baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UartClksPerBit
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops bytes from an upstream FIFO. All outputs are registered.
// The integrating level must not write the FIFO in a cycle where fifo_read_en is high.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UartClksPerBit,
  parameter int unsigned DATA_BITS    = UartDataBits
) (
  input logic            clk,
  input logic            rst,
  fifo_uart_tx_if.master bus
);

  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic                 stop_done_q, stop_done_d;
  logic                 tx_q, tx_d;
  logic                 read_en_q, read_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q;
  logic                 baud_en, baud_clr, baud_tick;

  assign baud_en  = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
  assign baud_clr = (state_d != state_q);

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .enable(baud_en),
    .clear (baud_clr),
    .tick  (baud_tick)
  );

  // tx is derived from the current state and registered, so the line trails the state by
  // one cycle; read_en and busy are derived from the next state and line up with it.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    stop_done_d = 1'b0;
    tx_d        = 1'b1;
    case (state_q)
      StIdle: begin
        if (!bus.fifo_empty) state_d = StFetch;
      end
      StFetch: begin
        state_d = StLoad;
      end
      StLoad: begin
        shift_d = bus.fifo_data;
        state_d = StStart;
      end
      StStart: begin
        tx_d = 1'b0;
        if (baud_tick) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        tx_d = shift_q[0];
        if (baud_tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LastIdx) state_d = StStop;
        end
      end
      StStop: begin
        if (baud_tick) begin
          state_d     = StIdle;
          stop_done_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    read_en_d = (state_d == StFetch);
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      stop_done_q <= 1'b0;
      tx_q        <= 1'b1;
      read_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      stop_done_q <= stop_done_d;
      tx_q        <= tx_d;
      read_en_q   <= read_en_d;
      busy_q      <= busy_d;
      done_q      <= stop_done_q;  // pulses in the first IDLE cycle after STOP
    end
  end

  assign bus.tx           = tx_q;
  assign bus.fifo_read_en = read_en_q;
  assign bus.busy         = busy_q;
  assign bus.tx_done      = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: a FIFO model feeds two transmitters (4 and 2 clocks per bit) while
// line monitors decode frames and compare them against the queued bytes.
module tb_fifo_uart_tx;

  localparam int CA = 4;
  localparam int CB = 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_uart_tx_if ia ();
  fifo_uart_tx_if ib ();

  fifo_uart_tx #(.CLKS_PER_BIT(CA), .DATA_BITS(8)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  fifo_uart_tx #(.CLKS_PER_BIT(CB), .DATA_BITS(8)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] fq_a[$], fq_b[$], exp_a[$], exp_b[$];
  int         start_a[$], start_b[$];
  logic [7:0] pend_a, pend_b;
  bit         pend_va = 1'b0, pend_vb = 1'b0;
  bit         mon_en  = 1'b0;
  int         pops_a = 0, pops_b = 0, done_a = 0, done_b = 0, re_viol = 0, frames_a = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
  endtask

  // One clock of the FIFO model: a pop seen in a cycle delivers its byte during the next.
  task automatic step();
    @(negedge clk);
    ia.fifo_data = pend_va ? pend_a : 8'($urandom);
    ib.fifo_data = pend_vb ? pend_b : 8'($urandom);
    pend_va = 1'b0;
    pend_vb = 1'b0;
    if (rst === 1'b1 && ia.fifo_read_en === 1'b1) begin
      pops_a++;
      if (fq_a.size() > 0) begin pend_a = fq_a.pop_front(); pend_va = 1'b1; end
      ia.fifo_empty = (fq_a.size() == 0);
    end
    if (rst === 1'b1 && ib.fifo_read_en === 1'b1) begin
      pops_b++;
      if (fq_b.size() > 0) begin pend_b = fq_b.pop_front(); pend_vb = 1'b1; end
      ib.fifo_empty = (fq_b.size() == 0);
    end
  endtask

  task automatic push_a(input logic [7:0] b, input bit track);
    for (int i = 0; i < 4 && ia.fifo_read_en === 1'b1; i++) step();
    fq_a.push_back(b);
    if (track) begin exp_a.push_back(b); frames_a++; end
    ia.fifo_empty = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] b);
    fq_b.push_back(b);
    exp_b.push_back(b);
    ib.fifo_empty = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (n < budget && !(fq_a.size() == 0 && fq_b.size() == 0 && exp_a.size() == 0 &&
           exp_b.size() == 0 && !pend_va && !pend_vb && ia.busy === 1'b0 && ib.busy === 1'b0))
    begin
      step();
      n++;
    end
    check({name, "_drain"}, n < budget, 1);
  endtask

  // Line decoder: 10 bits of c samples each, then tx_done expected on the next cycle.
  task automatic rx_run(input bit sel, input int c);
    logic       prev = 1'b1;
    logic       v;
    logic [9:0] bits;
    bit         steady, early;
    string      pfx;
    pfx = sel ? "b" : "a";
    forever begin
      @(negedge clk);
      v = sel ? ib.tx : ia.tx;
      if (mon_en && rst === 1'b1 && prev === 1'b1 && v === 1'b0) begin
        steady = 1'b1;
        early  = 1'b0;
        bits   = '0;
        if (sel) start_b.push_back(cyc);
        else start_a.push_back(cyc);
        for (int n = 0; n < 10 * c; n++) begin
          if (n != 0) begin
            @(negedge clk);
            v = sel ? ib.tx : ia.tx;
          end
          if (n % c == 0) bits[n / c] = v;
          else if (v !== bits[n / c]) steady = 1'b0;
          if ((sel ? ib.tx_done : ia.tx_done) !== 1'b0) early = 1'b1;
        end
        @(negedge clk);
        check({pfx, "_frame_shape"}, {bits[0], bits[9], steady, early}, 4'b0110);
        check({pfx, "_done_timing"}, sel ? ib.tx_done : ia.tx_done, 1);
        if (sel) begin
          if (exp_b.size() == 0) check("b_unexpected_frame", 1, 0);
          else check("b_frame_data", bits[8:1], exp_b.pop_front());
        end else begin
          if (exp_a.size() == 0) check("a_unexpected_frame", 1, 0);
          else check("a_frame_data", bits[8:1], exp_a.pop_front());
        end
        v = sel ? ib.tx : ia.tx;
      end
      prev = v;
    end
  endtask

  initial rx_run(1'b0, CA);
  initial rx_run(1'b1, CB);

  initial begin : pulse_mon
    logic re_prev_a = 1'b0, re_prev_b = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (ia.tx_done === 1'b1) done_a++;
        if (ib.tx_done === 1'b1) done_b++;
        if (ia.fifo_read_en === 1'b1 && re_prev_a) re_viol++;
        if (ib.fifo_read_en === 1'b1 && re_prev_b) re_viol++;
      end
      re_prev_a = (ia.fifo_read_en === 1'b1);
      re_prev_b = (ib.fifo_read_en === 1'b1);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: actual cycle %0d required completion", cyc);
    $fatal(1);
  end

  initial begin : stim
    int t0, n0, pa0, da0, viol, n, gap, k;
    rst           = 1'b0;
    ia.fifo_empty = 1'b0;
    ia.fifo_data  = 8'h00;
    ib.fifo_empty = 1'b1;
    ib.fifo_data  = 8'h00;

    // Reset held with the FIFO claiming data.
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_outputs", {ia.tx, ia.fifo_read_en, ia.busy, ia.tx_done}, 4'b1000);
    end
    ia.fifo_empty = 1'b1;
    rst           = 1'b1;
    mon_en        = 1'b1;

    viol = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if ({ia.tx, ia.fifo_read_en, ia.busy, ia.tx_done} !== 4'b1000) viol++;
    end
    check("empty_fifo_quiet", viol, 0);
    check("empty_fifo_no_pop", pops_a, 0);

    // Single byte: fall 3 edges after the first edge that samples fifo_empty low.
    step();
    t0  = cyc;
    pa0 = pops_a;
    n0  = start_a.size();
    push_a(8'hA5, 1'b1);
    drain("a5", 200);
    check("a5_start_latency", (start_a.size() > n0) ? start_a[n0] - (t0 + 1) : -1, 3);
    check("a5_single_pop", pops_a - pa0, 1);

    step();
    n0 = start_a.size();
    push_a(8'h00, 1'b1);
    push_a(8'hFF, 1'b1);
    drain("b2b", 300);
    check("b2b_frames", start_a.size() - n0, 2);
    gap = (start_a.size() >= n0 + 2) ? start_a[n0+1] - start_a[n0] : -1;
    check("b2b_start_gap", gap, 10 * CA + 3);

    for (int i = 0; i < 24; i++) begin
      push_a(8'($urandom), 1'b1);
      k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 60)) : 0;
      for (int j = 0; j < k; j++) step();
    end
    drain("random", 3000);

    // Abort during data bit 3 of 8'h3C; the following 8'h5A must still go out intact.
    mon_en = 1'b0;
    pa0    = pops_a;
    da0    = done_a;
    step();
    push_a(8'h3C, 1'b0);
    push_a(8'h5A, 1'b0);
    n = 0;
    while (n < 100 && ia.tx !== 1'b0) begin
      step();
      n++;
    end
    check("abort_frame_started", n < 100, 1);
    for (int i = 0; i < 4 * CA + 1; i++) step();
    rst = 1'b0;
    step();
    check("abort_outputs", {ia.tx, ia.fifo_read_en, ia.busy, ia.tx_done}, 4'b1000);
    rst    = 1'b1;
    mon_en = 1'b1;
    exp_a.push_back(8'h5A);
    frames_a++;
    drain("abort_next", 300);
    check("abort_done_pulses", done_a - da0, 1);
    check("abort_pops", pops_a - pa0, 2);

    step();
    t0 = cyc;
    push_b(8'h81);
    drain("b81", 200);
    check("b81_start_latency", (start_b.size() > 0) ? start_b[0] - (t0 + 1) : -1, 3);
    check("b81_done_once", done_b, 1);
    check("b81_single_pop", pops_b, 1);

    for (int i = 0; i < 5; i++) step();
    check("a_done_total", done_a, frames_a);
    check("a_pops_total", pops_a, frames_a + 1);
    check("read_en_never_consecutive", re_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
